// File: rtl/uart_rx_fifo_p.sv
// UART receive path: samples one line bit per baud_clk, checks parity/stop/break,
// and queues {OE,BE,FE,PE,data} entries in a show-ahead FIFO with overrun marking.
module uart_rx_fifo_p #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  localparam int AW = $clog2(DEPTH),
  localparam int EW = DATA_BITS + 4
) (
  input  logic          baud_clk,
  input  logic          rst_n,
  input  logic          data_in,
  input  logic          rd_en,
  output logic [EW-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          rx_busy,
  output logic          overrun
);

  localparam int            BW       = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
  localparam logic          PAR_EN_C = (PARITY_EN != 0);
  localparam logic          ODD_C    = (PARITY_ODD != 0);
  localparam logic          AF_RST   = (AF_LEVEL == 0);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DATA     = 3'd1,
    ST_PARITY   = 3'd2,
    ST_STOP     = 3'd3,
    ST_BRK_WAIT = 3'd4
  } state_e;

  function automatic logic parity_err(input logic [DATA_BITS-1:0] d, input logic s);
    return ((^d) ^ s) ^ ODD_C;
  endfunction

  state_e                 state_q, state_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   par_q, par_d;
  logic                   pe_q, pe_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic                   ovr_pend_q, ovr_pend_d;
  logic                   overrun_q, overrun_d;
  logic                   rx_busy_q, rx_busy_d;
  logic                   empty_q, empty_d;
  logic                   full_q, full_d;
  logic                   af_q, af_d;
  logic                   frame_done_s, fe_s, be_s;
  logic                   push_s, pop_s, drop_s;
  logic [EW-1:0]          wr_entry_s;
  logic [EW-1:0]          mem_q [DEPTH];

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    par_d        = par_q;
    pe_d         = pe_q;
    frame_done_s = 1'b0;
    fe_s         = 1'b0;
    be_s         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!data_in) begin
          state_d   = ST_DATA;
          bit_cnt_d = {BW{1'b0}};
          par_d     = 1'b0;
          pe_d      = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        data_d[bit_cnt_q] = data_in;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = PAR_EN_C ? ST_PARITY : ST_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      ST_PARITY: begin
        par_d   = data_in;
        pe_d    = parity_err(data_q, data_in);
        state_d = ST_STOP;
      end
      ST_STOP: begin
        frame_done_s = 1'b1;
        fe_s         = !data_in;
        // A break needs every sampled bit low, parity included when present.
        be_s         = fe_s && (data_q == {DATA_BITS{1'b0}}) && (!par_q || !PAR_EN_C);
        state_d      = be_s ? ST_BRK_WAIT : ST_IDLE;
      end
      ST_BRK_WAIT: begin
        state_d = data_in ? ST_IDLE : ST_BRK_WAIT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pop_s      = rd_en && !empty_q;
    push_s     = frame_done_s && (!full_q || pop_s);
    drop_s     = frame_done_s && !push_s;
    wr_entry_s = {ovr_pend_q, be_s, fe_s, pe_q, data_q};

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      ovr_pend_d = 1'b1;
    end else if (push_s) begin
      ovr_pend_d = 1'b0;
    end else begin
      ovr_pend_d = ovr_pend_q;
    end

    overrun_d = drop_s;
    rx_busy_d = (state_d != ST_IDLE);
    empty_d   = (count_d == {(AW + 1){1'b0}});
    full_d    = (count_d == DEPTH_C);
    af_d      = (32'(count_d) >= $unsigned(AF_LEVEL));
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= {BW{1'b0}};
      data_q     <= {DATA_BITS{1'b0}};
      par_q      <= 1'b0;
      pe_q       <= 1'b0;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW + 1){1'b0}};
      ovr_pend_q <= 1'b0;
      overrun_q  <= 1'b0;
      rx_busy_q  <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      af_q       <= AF_RST;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_q      <= par_d;
      pe_q       <= pe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovr_pend_q <= ovr_pend_d;
      overrun_q  <= overrun_d;
      rx_busy_q  <= rx_busy_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      af_q       <= af_d;
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge baud_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  assign rd_data     = mem_q[rd_ptr_q];
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign count       = count_q;
  assign rx_busy     = rx_busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo_p.sv
// Bench for uart_rx_fifo_p (8 data bits, even parity, depth 4): directed vectors,
// corner sequences and random frames checked against a queue-based model.
module tb_uart_rx_fifo_p;
  localparam int DEPTH = 4;
  localparam int AF    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_in;
  logic        rd_en;
  logic [11:0] rd_data;
  logic        empty, full, almost_full;
  logic [2:0]  count;
  logic        rx_busy, overrun;

  int total = 0;
  int bad   = 0;

  logic [11:0] mq[$];
  logic        ovr_m   = 1'b0;
  logic        exp_ovr = 1'b0;

  typedef struct {
    logic [7:0]  d;
    logic        p;
    logic        s;
    logic [11:0] exp;
  } vec_t;
  vec_t vt[8];

  uart_rx_fifo_p #(
    .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .DEPTH(DEPTH), .AF_LEVEL(AF)
  ) dut (
    .baud_clk(clk), .rst_n(rst_n), .data_in(data_in), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .rx_busy(rx_busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Entry fields from the frame rules: even parity, stop low = framing error,
  // all-low frame including parity = break.
  function automatic logic [11:0] exp_entry(input logic [7:0] d, input logic p, input logic s);
    logic pe, fe, be;
    pe = (^d) ^ p;
    fe = ~s;
    be = fe && (d == 8'h00) && !p;
    return {1'b0, be, fe, pe, d};
  endfunction

  function automatic logic rnd_rd(input int pct);
    return (int'($urandom_range(0, 99)) < pct);
  endfunction

  task automatic check_outputs(input logic busy_e);
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    chk("rx_busy", 32'(rx_busy), 32'(busy_e));
    if (mq.size() > 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
  endtask

  task automatic step(input logic din, input logic rd, input logic stop_e,
                      input logic [11:0] ent, input logic busy_e);
    data_in = din;
    rd_en   = rd;
    @(posedge clk);
    #1;
    if (rd && mq.size() > 0) mq.delete(0);
    exp_ovr = 1'b0;
    if (stop_e) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(ent | {ovr_m, 11'h000});
        ovr_m = 1'b0;
      end else begin
        ovr_m   = 1'b1;
        exp_ovr = 1'b1;
      end
    end
    check_outputs(busy_e);
  endtask

  task automatic frame(input logic [7:0] d, input logic p, input logic s,
                       input logic rd_stop, input int rd_pct);
    logic [11:0] e;
    e = exp_entry(d, p, s);
    step(1'b0, rnd_rd(rd_pct), 1'b0, 12'h000, 1'b1);
    for (int i = 0; i < 8; i++) step(d[i], rnd_rd(rd_pct), 1'b0, 12'h000, 1'b1);
    step(p, rnd_rd(rd_pct), 1'b0, 12'h000, 1'b1);
    step(s, rd_stop, 1'b1, e, e[10]);
  endtask

  task automatic idle(input logic rd);
    step(1'b1, rd, 1'b0, 12'h000, 1'b0);
  endtask

  initial begin
    logic [11:0] drain[4];
    logic [7:0]  d;
    logic        p, s, brk;
    int          gap;

    vt[0] = '{8'hA5, 1'b0, 1'b1, 12'h0A5};
    vt[1] = '{8'hA5, 1'b1, 1'b1, 12'h1A5};
    vt[2] = '{8'h3C, 1'b0, 1'b0, 12'h23C};
    vt[3] = '{8'h11, 1'b0, 1'b1, 12'h011};
    vt[4] = '{8'hFF, 1'b0, 1'b1, 12'h0FF};
    vt[5] = '{8'h00, 1'b0, 1'b0, 12'h600};
    vt[6] = '{8'h00, 1'b1, 1'b0, 12'h300};
    vt[7] = '{8'h80, 1'b0, 1'b1, 12'h180};

    rst_n   = 1'b0;
    data_in = 1'b1;
    rd_en   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs(1'b0);
    rst_n = 1'b1;
    idle(1'b0);

    // Directed single-frame vectors, each popped afterwards.
    for (int i = 0; i < 8; i++) begin
      frame(vt[i].d, vt[i].p, vt[i].s, 1'b0, 0);
      chk("vec_head", 32'(rd_data), 32'(vt[i].exp));
      chk("vec_count", 32'(count), 32'd1);
      idle(1'b1);
      chk("vec_empty_after_pop", 32'(empty), 32'd1);
    end

    // Line held low for 30 cycles: exactly one break entry.
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, (i == 10), exp_entry(8'h00, 1'b0, 1'b0), 1'b1);
    idle(1'b0);
    chk("brk_count", 32'(count), 32'd1);
    chk("brk_head", 32'(rd_data), 32'h600);
    frame(8'h11, 1'b0, 1'b1, 1'b0, 0);
    chk("brk_next_count", 32'(count), 32'd2);
    idle(1'b1);
    chk("brk_next_head", 32'(rd_data), 32'h011);
    idle(1'b1);

    // Overrun: fifth frame dropped, next stored entry carries OE.
    for (int k = 1; k <= 5; k++) begin
      d = 8'(k);
      frame(d, ^d, 1'b1, 1'b0, 0);
      if (k == 4) chk("ovr_full4", 32'(full), 32'd1);
    end
    chk("ovr_pulse", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(count), 32'd4);
    chk("ovr_head", 32'(rd_data), 32'h001);
    idle(1'b1);
    chk("ovr_pulse_gone", 32'(overrun), 32'd0);
    frame(8'h3C, 1'b0, 1'b1, 1'b0, 0);
    drain = '{12'h002, 12'h003, 12'h004, 12'h83C};
    for (int i = 0; i < 4; i++) begin
      chk("ovr_drain", 32'(rd_data), 32'(drain[i]));
      idle(1'b1);
    end
    chk("ovr_drained", 32'(empty), 32'd1);

    // Full FIFO with pop on the stop edge: no overrun, new frame kept.
    for (int k = 0; k < 4; k++) begin
      d = 8'h10 + 8'(k);
      frame(d, ^d, 1'b1, 1'b0, 0);
    end
    frame(8'h14, ^8'h14, 1'b1, 1'b1, 0);
    chk("fullpop_ovr", 32'(overrun), 32'd0);
    chk("fullpop_count", 32'(count), 32'd4);
    chk("fullpop_head", 32'(rd_data), 32'h011);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b1);
    chk("rd_empty_count", 32'(count), 32'd0);

    // Asynchronous reset mid-frame with two entries stored.
    frame(8'h21, ^8'h21, 1'b1, 1'b0, 0);
    frame(8'h22, ^8'h22, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 12'h000, 1'b1);
    data_in = 1'b1;
    rst_n   = 1'b0;
    #1;
    mq.delete();
    ovr_m   = 1'b0;
    exp_ovr = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1'b0);
    frame(8'h5A, ^8'h5A, 1'b1, 1'b0, 0);
    chk("rst_next_head", 32'(rd_data), 32'h05A);
    chk("rst_next_count", 32'(count), 32'd1);
    idle(1'b1);

    // Random frames, errors, breaks and pops against the queue model.
    for (int n = 0; n < 300; n++) begin
      brk = ($urandom_range(0, 19) == 0);
      d   = brk ? 8'h00 : 8'($urandom);
      p   = brk ? 1'b0 : (($urandom_range(0, 9) == 0) ? ~(^d) : ^d);
      s   = brk ? 1'b0 : ($urandom_range(0, 9) != 0);
      frame(d, p, s, ($urandom_range(0, 3) == 0), 15);
      gap = int'($urandom_range(0, 2));
      if (exp_entry(d, p, s) & 12'h400) gap = (gap == 0) ? 1 : gap;
      for (int g = 0; g < gap; g++) idle($urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
